// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions used by the memory responder: FSM states,
// request field encodings and the default memory latency.
package lc3b_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FAULT
   } mem_state_t;

   localparam logic RW_READ   = 1'b0;
   localparam logic RW_WRITE  = 1'b1;
   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   localparam int MEM_LATENCY = 5;

   // Request fields captured at acceptance and held for the whole access.
   typedef struct packed {
      logic [15:0] mar;
      logic [15:0] mdr;
      logic        r_w;
      logic        data_size;
   } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Datapath <-> memory handshake bundle; master is the initiator (control/datapath),
// slave is the memory responder.
interface mem_responder_if;

   logic        mio_en;
   logic        r_w;
   logic        data_size;
   logic [15:0] mar;
   logic [15:0] mdr_in;
   logic [15:0] mem_out;
   logic        r;
   logic        unaligned;

   modport master (
      output mio_en, r_w, data_size, mar, mdr_in,
      input  mem_out, r, unaligned
   );

   modport slave (
      input  mio_en, r_w, data_size, mar, mdr_in,
      output mem_out, r, unaligned
   );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 16-bit words with independent byte-lane write
// enables and a registered read port that holds its value between reads.
module mem_array #(
   parameter int WORDS  = 1024,
   parameter int ADDR_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   input  logic              we_lo,
   input  logic              we_hi,
   input  logic              rd_en,
   output logic [15:0]       rdata
);

   logic [15:0] mem [WORDS];

   // NOTE: the storage array has no reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we_lo) mem[addr][7:0]  <= wdata[7:0];
      if (we_hi) mem[addr][15:8] <= wdata[15:8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts a mio_en-framed request, waits
// LATENCY cycles, then pulses r while committing the write or capturing read data.
module mem_responder
   import lc3b_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = MEM_LATENCY
) (
   input  logic             clk,
   input  logic             reset_n,
   mem_responder_if.slave   bus
);

   localparam int         ADDR_W   = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   mem_state_t  state;
   logic [3:0]  cnt;
   mem_req_t    req;
   logic        r_q;
   logic        unaligned_q;

   logic        is_write;
   logic        we_lo;
   logic        we_hi;
   logic        rd_en;
   logic        unused_addr;

   // NOTE: all FSM state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         req         <= '0;
         r_q         <= 1'b0;
         unaligned_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mio_en) begin
                  if (bus.data_size == SIZE_WORD && bus.mar[0]) begin
                     state       <= FAULT;
                     unaligned_q <= 1'b1;
                  end else begin
                     req   <= '{mar: bus.mar, mdr: bus.mdr_in,
                                r_w: bus.r_w, data_size: bus.data_size};
                     cnt   <= CNT_LOAD;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  if (!bus.mio_en) begin
                     // Initiator gave up: drop the access silently.
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt - 4'd1;
                     r_q <= (cnt == 4'd1);
                  end
               end else begin
                  r_q   <= 1'b0;
                  state <= IDLE;
               end
            end
            FAULT: begin
               if (!bus.mio_en) begin
                  state       <= IDLE;
                  unaligned_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               r_q         <= 1'b0;
               unaligned_q <= 1'b0;
            end
         endcase
      end
   end

   // r_q is high exactly in the BUSY cycle with the counter at zero.
   assign is_write = r_q && (req.r_w == RW_WRITE);
   assign rd_en    = r_q && (req.r_w == RW_READ);
   assign we_lo    = is_write && (req.data_size == SIZE_WORD || !req.mar[0]);
   assign we_hi    = is_write && (req.data_size == SIZE_WORD ||  req.mar[0]);

   assign bus.r         = r_q;
   assign bus.unaligned = unaligned_q;

   // Address bits above the array size are ignored so the space wraps.
   assign unused_addr = ^req.mar;

   mem_array #(
      .WORDS (MEM_WORDS)
   ) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .addr    (req.mar[ADDR_W:1]),
      .wdata   (req.mdr),
      .we_lo   (we_lo),
      .we_hi   (we_hi),
      .rd_en   (rd_en),
      .rdata   (bus.mem_out)
   );

endmodule
